// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard query bundle between the decode stage (master) and the scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int LAT_W = 3,
  parameter int NREG  = 32
);
  logic             id_valid;
  logic             id_re0;
  logic [4:0]       id_ra0;
  logic             id_re1;
  logic [4:0]       id_ra1;
  logic             id_we;
  logic [4:0]       id_wa;
  logic [LAT_W-1:0] id_lat;
  logic             stall_id;
  logic [NREG-1:0]  pend_mask;
  logic             raw_hit;
  logic             waw_hit;

  modport master (
    output id_valid, id_re0, id_ra0, id_re1, id_ra1, id_we, id_wa, id_lat,
    input  stall_id, pend_mask, raw_hit, waw_hit
  );

  modport slave (
    input  id_valid, id_re0, id_ra0, id_re1, id_ra1, id_we, id_wa, id_lat,
    output stall_id, pend_mask, raw_hit, waw_hit
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard raising ID stalls on load-use, long-latency RAW and WAW hazards.
// Optional HAZ_STATS_EN adds saturating stall/RAW/WAW cycle counters.
module hazard_scoreboard #(
  parameter int LAT_W = 3,
  parameter int NREG  = 32
) (
  input  logic                clk,
  input  logic                rstn,
  hazard_scoreboard_if.slave  sb
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         raw_cycles,
  output logic [31:0]         waw_cycles
`endif
);

  logic [LAT_W-1:0] cnt [NREG];
  logic             raw0;
  logic             raw1;
  logic             raw_hit;
  logic             waw_hit;
  logic             stall;
  logic             issue;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Hazard detection against the pre-edge scoreboard state
  always_comb begin
    raw0    = sb.id_re0 && (sb.id_ra0 != 5'd0) && (cnt[sb.id_ra0] != '0);
    raw1    = sb.id_re1 && (sb.id_ra1 != 5'd0) && (cnt[sb.id_ra1] != '0);
    raw_hit = sb.id_valid && (raw0 || raw1);
    waw_hit = sb.id_valid && sb.id_we && (sb.id_wa != 5'd0) && (cnt[sb.id_wa] > sb.id_lat);
    stall   = raw_hit || waw_hit;
    issue   = sb.id_valid && !stall;
  end

  assign sb.raw_hit  = raw_hit;
  assign sb.waw_hit  = waw_hit;
  assign sb.stall_id = stall;

  always_comb begin
    sb.pend_mask = '0;
    for (int i = 1; i < NREG; i++) begin
      sb.pend_mask[i] = (cnt[i] != '0);
    end
  end

  // Back end never stalls, so countdowns run every cycle; a fresh insert overrides the decrement
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (issue && sb.id_we && (sb.id_wa == 5'(i)) && (sb.id_lat != '0)) begin
          cnt[i] <= sb.id_lat;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - LAT_W'(1);
        end
      end
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
      raw_cycles   <= '0;
      waw_cycles   <= '0;
    end else begin
      if (stall)   stall_cycles <= sat_inc(stall_cycles);
      if (raw_hit) raw_cycles   <= sat_inc(raw_cycles);
      if (waw_hit) waw_cycles   <= sat_inc(waw_cycles);
    end
  end
`endif

endmodule
